// File: rtl/arb_pkg.sv
// Shared definitions for the parametrised arbiter: mode encodings, FSM state type,
// and width/one-hot helpers usable in constant expressions.
package arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Widest requester vector the conversion helpers support.
    localparam int MAX_N   = 32;
    localparam int MAX_IDW = 5;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic logic [MAX_N-1:0] idx_to_onehot(input logic [MAX_IDW-1:0] idx);
        logic [MAX_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    function automatic logic [MAX_IDW-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular picker: first unmasked request at or above i_ptr, wrapping
// to index 0. Fixed priority is the special case i_ptr = 0.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    input  logic [N-1:0]   i_mask,
    output logic           o_found,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx
);

    logic [N-1:0] w_eff;

    assign w_eff = i_req & ~i_mask;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips one would infer a latch.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        // Upper segment [ptr, N-1] first, then the wrapped segment [0, ptr-1].
        for (int j = 0; j < N; j++) begin
            if (!o_found && w_eff[j] && (j >= int'(i_ptr))) begin
                o_found = 1'b1;
                o_idx   = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!o_found && w_eff[j] && (j < int'(i_ptr))) begin
                o_found = 1'b1;
                o_idx   = IDW'(j);
            end
        end
    end

    assign o_gnt = o_found ? N'(idx_to_onehot(MAX_IDW'(o_idx))) : '0;

endmodule

// File: rtl/param_rr_arbiter.sv
// N-way arbiter with run-time fixed-priority / round-robin select, registered one-hot
// grant, and a hold limit that forces re-arbitration after MAX_HOLD cycles of ownership.
module param_rr_arbiter
    import arb_pkg::*;
#(
    parameter  int N        = 4,
    parameter  int MAX_HOLD = 8,
    localparam int IDW      = (N > 1) ? clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode_i,
    input  logic [N-1:0]   req_i,
    output logic [N-1:0]   gnt_o,
    output logic           gnt_valid_o,
    output logic [IDW-1:0] gnt_id_o
);

    localparam int HC_MIN    = (MAX_HOLD > 1) ? clog2(MAX_HOLD) : 1;
    localparam int HCW       = (HC_MIN > IDW) ? HC_MIN : IDW;
    localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

    arb_state_t     r_state;
    logic [N-1:0]   r_gnt;
    logic           r_valid;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_ptr;
    logic [HCW-1:0] r_hold_cnt;

    arb_state_t     w_next_state;
    logic [N-1:0]   w_next_gnt;
    logic [IDW-1:0] w_next_id;
    logic [IDW-1:0] w_next_ptr;
    logic [HCW-1:0] w_next_hold;
    logic           w_take;

    logic           w_owner_req;
    logic           w_expired;
    logic [N-1:0]   w_mask;
    logic [IDW-1:0] w_start;
    logic           w_found;
    logic [N-1:0]   w_pick_gnt;
    logic [IDW-1:0] w_pick_idx;

    // r_gnt is the owner's one-hot, so masking with it tests/excludes the owner.
    assign w_owner_req = (r_state == ST_OWNED) && |(req_i & r_gnt);
    assign w_expired   = (MAX_HOLD != 0) && (r_hold_cnt >= HCW'(HOLD_LAST));
    assign w_mask      = w_owner_req ? r_gnt : '0;
    assign w_start     = (mode_i == MODE_RR) ? r_ptr : '0;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .i_req   (req_i),
        .i_ptr   (w_start),
        .i_mask  (w_mask),
        .o_found (w_found),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = r_gnt;
        w_next_id    = r_id;
        w_next_ptr   = r_ptr;
        w_next_hold  = r_hold_cnt;
        w_take       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_take = w_found;
            end
            ST_OWNED: begin
                if (w_owner_req && !w_expired) begin
                    if (r_hold_cnt != '1) w_next_hold = r_hold_cnt + 1'b1;
                end else if (w_owner_req) begin
                    // Hold expired: hand over if anyone else wants it, else restart the owner's count.
                    w_take      = w_found;
                    w_next_hold = '0;
                end else if (w_found) begin
                    w_take = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                    w_next_gnt   = '0;
                    w_next_id    = '0;
                    w_next_hold  = '0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_gnt   = '0;
                w_next_id    = '0;
                w_next_hold  = '0;
            end
        endcase

        if (w_take) begin
            w_next_state = ST_OWNED;
            w_next_gnt   = w_pick_gnt;
            w_next_id    = w_pick_idx;
            w_next_hold  = '0;
            w_next_ptr   = (w_pick_idx == IDW'(N - 1)) ? '0 : w_pick_idx + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_valid    <= 1'b0;
            r_id       <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_gnt      <= w_next_gnt;
            r_valid    <= |w_next_gnt;
            r_id       <= w_next_id;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= w_next_hold;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = r_valid;
    assign gnt_id_o    = r_id;

endmodule
